// File: rtl/scan_pkg.sv
// Shared definitions for the channel scan controller: state encoding,
// default dwell width and the channel step helper.
package scan_pkg;

    localparam int DWELL_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_t;

    // Channel indices wrap modulo 16 in both directions.
    function automatic logic [3:0] step_ch(input logic [3:0] ch, input logic down);
        return down ? (ch - 4'd1) : (ch + 4'd1);
    endfunction

endpackage

// File: rtl/decoder_4to16.sv
// One-hot 4-to-16 decoder driven by the scan controller's channel index.
module decoder_4to16 (
    input  logic [3:0]  binary_in,
    input  logic        enable,
    output logic [15:0] decoder_out
);

    assign decoder_out = enable ? (16'h0001 << binary_in) : 16'h0000;

endmodule

// File: rtl/dwell_timer.sv
// Per-channel dwell counter: counts up to a limit, flags terminal count,
// and wraps to zero on the terminal cycle.
module dwell_timer
    import scan_pkg::*;
#(
    parameter int W = DWELL_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clear,
    input  logic         i_count,
    input  logic [W-1:0] i_limit,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    assign o_tc = (r_count == i_limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count) begin
            r_count <= o_tc ? '0 : (r_count + W'(1));
        end
    end

endmodule

// File: rtl/channel_scan_ctrl.sv
// Channel scan sequencer: steps a 4-bit channel index from first_ch to last_ch,
// holding each channel dwell+1 cycles, in single-pass or looping mode.
module channel_scan_ctrl
    import scan_pkg::*;
#(
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               loop_mode,
    input  logic               dir,
    input  logic [3:0]         first_ch,
    input  logic [3:0]         last_ch,
    input  logic [DWELL_W-1:0] dwell,
    output logic [3:0]         binary_in,
    output logic               enable,
    output logic               busy,
    output logic               done
);

    scan_state_t        r_state;
    logic [3:0]         r_first;
    logic [3:0]         r_last;
    logic               r_dir;
    logic               r_loop;
    logic [DWELL_W-1:0] r_dwell;

    logic w_tc;
    logic w_timer_clear;
    logic w_timer_count;

    assign w_timer_count = (r_state == ST_SCAN);
    assign w_timer_clear = (r_state != ST_SCAN) || stop;

    dwell_timer #(.W(DWELL_W)) u_dwell_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_timer_clear),
        .i_count (w_timer_count),
        .i_limit (r_dwell),
        .o_tc    (w_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_first   <= '0;
            r_last    <= '0;
            r_dir     <= 1'b0;
            r_loop    <= 1'b0;
            r_dwell   <= '0;
            binary_in <= '0;
            enable    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start && !stop) begin
                        r_first   <= first_ch;
                        r_last    <= last_ch;
                        r_dir     <= dir;
                        r_loop    <= loop_mode;
                        r_dwell   <= dwell;
                        binary_in <= first_ch;
                        enable    <= 1'b1;
                        busy      <= 1'b1;
                        r_state   <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    // Abort beats everything, including the final advance.
                    if (stop) begin
                        enable  <= 1'b0;
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_tc) begin
                        if (binary_in != r_last) begin
                            binary_in <= step_ch(binary_in, r_dir);
                        end else if (r_loop) begin
                            binary_in <= r_first;
                        end else begin
                            enable  <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    enable  <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_channel_scan_ctrl.sv
// Bench for channel_scan_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based pass model.
module tb_channel_scan_ctrl;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          loop_mode = 1'b0;
    logic          dir = 1'b0;
    logic [3:0]    first_ch = 4'd0;
    logic [3:0]    last_ch = 4'd0;
    logic [DW-1:0] dwell = '0;
    logic [3:0]    binary_in;
    logic          enable;
    logic          busy;
    logic          done;
    logic [15:0]   decoder_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    channel_scan_ctrl #(.DWELL_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .loop_mode (loop_mode),
        .dir       (dir),
        .first_ch  (first_ch),
        .last_ch   (last_ch),
        .dwell     (dwell),
        .binary_in (binary_in),
        .enable    (enable),
        .busy      (busy),
        .done      (done)
    );

    decoder_4to16 u_dec (
        .binary_in   (binary_in),
        .enable      (enable),
        .decoder_out (decoder_out)
    );

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
        end
    endtask

    // A pass is the list of channel indices seen per cycle, each repeated dwell+1 times.
    int p_q[$];
    task automatic build_pass(input int f, input int l, input bit d, input int dw);
        int n;
        int ch;
        p_q.delete();
        n = d ? (((f - l) & 15) + 1) : (((l - f) & 15) + 1);
        for (int k = 0; k < n; k++) begin
            ch = d ? ((f - k) & 15) : ((f + k) & 15);
            for (int r = 0; r <= dw; r++) p_q.push_back(ch);
        end
    endtask

    int m_phase = 0;
    int m_bin = 0;
    bit m_en = 1'b0;
    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    int m_q[$];
    int c_first = 0;
    int c_last = 0;
    int c_dwell = 0;
    bit c_dir = 1'b0;
    bit c_loop = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0; m_bin = 0; m_en = 1'b0; m_busy = 1'b0; m_done = 1'b0;
            m_q.delete();
        end else begin
            case (m_phase)
                0: begin
                    m_done = 1'b0;
                    if (start && !stop) begin
                        c_first = int'(first_ch); c_last = int'(last_ch);
                        c_dir = dir; c_loop = loop_mode; c_dwell = int'(dwell);
                        build_pass(c_first, c_last, c_dir, c_dwell);
                        m_q = p_q;
                        m_bin = m_q.pop_front();
                        m_phase = 1; m_en = 1'b1; m_busy = 1'b1;
                    end
                end
                1: begin
                    if (stop) begin
                        m_phase = 0; m_en = 1'b0; m_busy = 1'b0;
                    end else if (m_q.size() == 0) begin
                        if (c_loop) begin
                            build_pass(c_first, c_last, c_dir, c_dwell);
                            m_q = p_q;
                            m_bin = m_q.pop_front();
                        end else begin
                            m_phase = 2; m_en = 1'b0; m_busy = 1'b0; m_done = 1'b1;
                        end
                    end else begin
                        m_bin = m_q.pop_front();
                    end
                end
                default: begin
                    m_done = 1'b0; m_phase = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_binary_in", 32'(binary_in), 32'd0);
            check("rst_enable", 32'(enable), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
        end else begin
            check("mdl_binary_in", 32'(binary_in), 32'(m_bin));
            check("mdl_enable", 32'(enable), 32'(m_en));
            check("mdl_busy", 32'(busy), 32'(m_busy));
            check("mdl_done", 32'(done), 32'(m_done));
            check("mdl_decoder", 32'(decoder_out), m_en ? (32'd1 << m_bin) : 32'd0);
        end
    end

    // Called at a negedge; config is scrambled right after the start cycle.
    task automatic do_start(input int f, input int l, input bit d, input bit lp, input int dw);
        first_ch = 4'(f); last_ch = 4'(l); dir = d; loop_mode = lp; dwell = DW'(dw);
        start = 1'b1; stop = 1'b0;
        @(negedge clk);
        start = 1'b0;
        first_ch = 4'($urandom); last_ch = 4'($urandom);
        dir = 1'($urandom); loop_mode = 1'($urandom); dwell = DW'($urandom);
    endtask

    int e32[8] = '{2, 2, 3, 3, 4, 4, 5, 5};
    logic [15:0] d32[8] = '{16'h0004, 16'h0004, 16'h0008, 16'h0008,
                            16'h0010, 16'h0010, 16'h0020, 16'h0020};
    int e33[4] = '{14, 15, 0, 1};
    int e34[8] = '{1, 0, 15, 14, 1, 0, 15, 14};
    int ep[8]  = '{14, 14, 15, 15, 0, 0, 1, 1};

    initial begin
        build_pass(14, 1, 1'b0, 1);
        check("pin_pass_len", 32'(p_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) check("pin_pass_val", 32'(p_q[i]), 32'(ep[i]));
        build_pass(7, 7, 1'b1, 3);
        check("pin_single_len", 32'(p_q.size()), 32'd4);

        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("reset_binary_in", 32'(binary_in), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);

        // 2..5 up, two cycles per channel
        do_start(2, 5, 1'b0, 1'b0, 1);
        for (int i = 0; i < 8; i++) begin
            check("t1_binary_in", 32'(binary_in), 32'(e32[i]));
            check("t1_enable", 32'(enable), 32'd1);
            check("t1_decoder", 32'(decoder_out), 32'(d32[i]));
            @(negedge clk);
        end
        check("t1_done_pulse", 32'(done), 32'd1);
        check("t1_enable_off", 32'(enable), 32'd0);
        @(negedge clk);
        check("t1_done_clear", 32'(done), 32'd0);

        // wrap 15->0 going up, dwell 0
        do_start(14, 1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            check("t2_binary_in", 32'(binary_in), 32'(e33[i]));
            @(negedge clk);
        end
        check("t2_done_pulse", 32'(done), 32'd1);
        @(negedge clk);

        // loop downward, then abort
        do_start(1, 14, 1'b1, 1'b1, 0);
        for (int i = 0; i < 8; i++) begin
            check("t3_binary_in", 32'(binary_in), 32'(e34[i]));
            @(negedge clk);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("t3_stop_enable", 32'(enable), 32'd0);
        check("t3_stop_busy", 32'(busy), 32'd0);
        check("t3_stop_hold", 32'(binary_in), 32'd1);
        check("t3_stop_nodone", 32'(done), 32'd0);
        @(negedge clk);
        check("t3_stop_nodone2", 32'(done), 32'd0);

        // single channel, dwell 3, start mid-scan ignored
        do_start(7, 7, 1'b0, 1'b0, 3);
        for (int i = 0; i < 4; i++) begin
            check("t4_binary_in", 32'(binary_in), 32'd7);
            check("t4_busy", 32'(busy), 32'd1);
            start = (i == 1);
            @(negedge clk);
        end
        start = 1'b0;
        check("t4_done_pulse", 32'(done), 32'd1);
        @(negedge clk);
        check("t4_idle_after", 32'(busy), 32'd0);

        // async reset mid-scan at channel 9
        do_start(5, 12, 1'b0, 1'b0, 0);
        repeat (4) @(negedge clk);
        check("t5_at_nine", 32'(binary_in), 32'd9);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("t5_async_bin", 32'(binary_in), 32'd0);
        check("t5_async_en", 32'(enable), 32'd0);
        check("t5_async_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("t5_stays_idle", 32'(busy), 32'd0);
        end

        // start+stop together, then stop on last dwell cycle of final channel
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check("t6_startstop_busy", 32'(busy), 32'd0);
        do_start(3, 4, 1'b0, 1'b0, 1);
        for (int i = 0; i < 4; i++) begin
            stop = (i == 3);
            @(negedge clk);
        end
        stop = 1'b0;
        check("t6_final_stop_done", 32'(done), 32'd0);
        check("t6_final_stop_en", 32'(enable), 32'd0);
        @(negedge clk);
        check("t6_final_stop_done2", 32'(done), 32'd0);

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 7) == 0);
            stop = ($urandom_range(0, 29) == 0);
            loop_mode = ($urandom_range(0, 3) == 0);
            dir = 1'($urandom);
            first_ch = 4'($urandom);
            last_ch = 4'($urandom);
            dwell = DW'($urandom_range(0, 3));
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end

        start = 1'b0; stop = 1'b0;
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
